btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Input conditioning stage directly upstream of the micro-debug controller.
- Takes raw, asynchronous, bouncing board buttons and switches: PC-enable, external-control, micro-reset, and the 6 control buttons.
- Produces synchronised, debounced levels plus single-cycle press/release strobes.
- Selected channels can generate auto-repeat press strobes while held, so single-stepping can be driven by holding a button.

Parameters:
- N, 9, number of input channels. Bit mapping: [0] PCenBtn, [1] extCtlBtn, [2] micRstBtn, [8:3] ctrlBtns[5:0].
- DEBOUNCE_CYC, 1_000_000, consecutive stable synchronised cycles required before the level changes. Must be >=1.
- REPEAT_DELAY, 50_000_000, cycles from the press strobe to the first auto-repeat strobe. Must be >=1.
- REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat strobes. Must be >=1.
- REPEAT_MASK, 9'b0_0000_0001, per-channel auto-repeat enable. Bit i = 1 enables repeat on channel i.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  N  raw pad inputs, asynchronous to clk, active-high.
- btn_level  out  N  debounced level.
- btn_press  out  N  one-cycle strobe on debounced rise, and on each auto-repeat.
- btn_release  out  N  one-cycle strobe on debounced fall.

Behaviour:
- All state is asynchronously cleared while rst=0. Reset values:
  - btn_level=0, btn_press=0, btn_release=0.
  - Synchroniser flops = 0.
  - All counters = 0.
- Leaving reset is synchronous to clk: first update at the first rising edge with rst=1.
- Synchroniser: 2-flop chain per channel. sync[i] is btn_raw[i] delayed by 2 edges. No other logic reads btn_raw.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYC+1):
  - If sync==btn_level: cnt<=0.
  - Else if cnt==DEBOUNCE_CYC-1: btn_level<=sync, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any return of sync to the current level before the terminal count restarts the count from 0.
- Latency: a clean raw edge sampled at edge E appears on btn_level at edge E+1+DEBOUNCE_CYC.
- Strobes are registered and asserted for exactly one cycle:
  - btn_press[i] on the same edge that btn_level[i] goes 0->1.
  - btn_release[i] on the same edge that btn_level[i] goes 1->0.
  - press and release are never both high on the same channel in the same cycle.
- Auto-repeat (only for channels with REPEAT_MASK[i]=1):
  - Each such channel has its own repeat counter rcnt and a flag first.
  - On a debounced rise: rcnt<=0, first<=1.
  - While btn_level=1: rcnt increments each cycle.
  - When rcnt reaches (first ? REPEAT_DELAY : REPEAT_RATE)-1: btn_press pulses for one cycle, rcnt<=0, first<=0.
  - On a debounced fall, or whenever btn_level=0: rcnt<=0, and no repeat strobes are generated.
  - Masked-off channels never auto-repeat, and their repeat logic must synthesise away.
- Channels are fully independent. Simultaneous events on multiple channels produce simultaneous strobes on each.
- Reset asserted mid-count or mid-hold:
  - Everything clears immediately.
  - After release, a still-held button is treated as a new press: a full DEBOUNCE_CYC wait, then a press strobe.
- Counters must never wrap. The terminal comparisons above bound every counter.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=5, REPEAT_MASK=9'h001.
- Clean press: btn_raw[3] 0->1 before edge 0 and held -> btn_level[3]=1 and btn_press[3]=1 at edge 5; btn_press[3]=0 at edge 6; btn_release stays 0.
- Bounce rejection: btn_raw[1] toggles every 3 cycles for 30 cycles, then settles at 0 -> btn_level[1] stays 0; no press or release strobes.
- Release: after scenario 1, btn_raw[3] 1->0 -> btn_release[3] one-cycle pulse and btn_level[3]=0, both 5 edges later.
- Auto-repeat: btn_raw[0] held for 40 cycles:
  - initial press at edge 5;
  - repeats at edges 15, 20, 25, 30, 35, 40;
  - after release, no further press strobes.
  - Same stimulus on btn_raw[2] (not masked) -> exactly one press strobe.
- Async reset mid-count: btn_raw[4]=1 held, rst=0 asserted between edges 3 and 4 (not on an edge) -> all outputs 0 immediately. After rst=1, btn_press[4] fires 5 edges after the first active edge.
- Simultaneous: btn_raw = 9'h1FF at once -> all 9 btn_press bits pulse on the same edge; btn_level = 9'h1FF.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw pad levels in, debounced level and strobes out.
// The master side owns the raw pads (board / testbench). The slave side is
// the conditioner itself.
interface btn_conditioner_if #(
    parameter int N = 9
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_conditioner.sv
// Button/switch input conditioner for the micro-debug controller.
// Each channel is synchronised through two flops, then debounced with a
// counter. The debounce stage produces registered one-cycle press and
// release strobes. Channels selected by REPEAT_MASK also emit auto-repeat
// press strobes while held, so that holding a button can drive single-stepping.
// Channel map: [0] PCen, [1] extCtl, [2] micRst, [8:3] ctrl buttons.

// Invariant checker for the conditioner outputs (simulation only).
module btn_conditioner_chk #(
    parameter int N = 9
) (
    input logic         clk,
    input logic         rst,
    input logic [N-1:0] level,
    input logic [N-1:0] press,
    input logic [N-1:0] rel
);
    // A channel never strobes press and release together.
    a_press_rel_excl: assert property (@(posedge clk) disable iff (!rst)
        (press & rel) == {N{1'b0}});

    // A press strobe is only ever seen with the level high.
    a_press_level: assert property (@(posedge clk) disable iff (!rst)
        (press & ~level) == {N{1'b0}});

    // A release strobe is only ever seen with the level low.
    a_rel_level: assert property (@(posedge clk) disable iff (!rst)
        (rel & level) == {N{1'b0}});
endmodule

module btn_conditioner #(
    parameter int           N            = 9,
    parameter int           DEBOUNCE_CYC = 1_000_000,
    parameter int           REPEAT_DELAY = 50_000_000,
    parameter int           REPEAT_RATE  = 10_000_000,
    parameter logic [N-1:0] REPEAT_MASK  = 9'b0_0000_0001
) (
    input logic              clk,
    input logic              rst,
    btn_conditioner_if.slave bus
);
    // Debounce counter only has to hold 0..DEBOUNCE_CYC-1.
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    // Repeat counter only has to hold 0..max(delay,rate)-1.
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_TERM = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_TERM = RW'(REPEAT_RATE - 1);

    logic [N-1:0] level_vec_s;
    logic [N-1:0] press_vec_s;
    logic [N-1:0] release_vec_s;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          sync1_r;
        logic          sync2_r;
        logic [DW-1:0] cnt_r;
        logic [DW-1:0] cnt_nxt_s;
        logic          level_r;
        logic          level_nxt_s;
        logic          press_r;
        logic          release_r;
        logic          rise_s;
        logic          fall_s;
        logic          rep_hit_s;

        // Two-flop synchroniser: the only reader of the asynchronous pad.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= bus.btn_raw[i];
                sync2_r <= sync1_r;
            end
        end

        // Debounce next state: the level follows sync only after it has
        // disagreed with the level for DEBOUNCE_CYC consecutive cycles.
        always_comb begin
            cnt_nxt_s   = {DW{1'b0}};
            level_nxt_s = level_r;
            if (sync2_r == level_r) begin
                cnt_nxt_s = {DW{1'b0}};
            end else if (cnt_r == DB_TERM) begin
                level_nxt_s = sync2_r;
                cnt_nxt_s   = {DW{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + DW'(1);
            end
        end

        assign rise_s = level_nxt_s & ~level_r;
        assign fall_s = ~level_nxt_s & level_r;

        // Registered debounced level plus one-cycle edge/repeat strobes.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_r     <= {DW{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_nxt_s;
                level_r   <= level_nxt_s;
                press_r   <= rise_s | rep_hit_s;
                release_r <= fall_s;
            end
        end

        if (REPEAT_MASK[i]) begin : g_rep
            logic [RW-1:0] rcnt_r;
            logic [RW-1:0] rcnt_nxt_s;
            logic [RW-1:0] term_s;
            logic          first_r;
            logic          first_nxt_s;
            logic          hit_s;

            // Repeat next state. The first repeat waits REPEAT_DELAY and
            // later ones wait REPEAT_RATE. On the fall edge no repeat is
            // issued, so press and release never coincide.
            always_comb begin
                hit_s       = 1'b0;
                rcnt_nxt_s  = {RW{1'b0}};
                first_nxt_s = first_r;
                term_s      = first_r ? RD_TERM : RR_TERM;
                if (rise_s) begin
                    first_nxt_s = 1'b1;
                end else if (level_r && level_nxt_s) begin
                    if (rcnt_r == term_s) begin
                        hit_s       = 1'b1;
                        first_nxt_s = 1'b0;
                    end else begin
                        rcnt_nxt_s = rcnt_r + RW'(1);
                    end
                end else begin
                    rcnt_nxt_s = {RW{1'b0}};
                end
            end

            // Repeat counter and first-repeat flag.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rcnt_r  <= {RW{1'b0}};
                    first_r <= 1'b0;
                end else begin
                    rcnt_r  <= rcnt_nxt_s;
                    first_r <= first_nxt_s;
                end
            end

            assign rep_hit_s = hit_s;
        end else begin : g_norep
            assign rep_hit_s = 1'b0;
        end

        assign level_vec_s[i]   = level_r;
        assign press_vec_s[i]   = press_r;
        assign release_vec_s[i] = release_r;
    end

    assign bus.btn_level   = level_vec_s;
    assign bus.btn_press   = press_vec_s;
    assign bus.btn_release = release_vec_s;

    btn_conditioner_chk #(
        .N (N)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .level (level_vec_s),
        .press (press_vec_s),
        .rel   (release_vec_s)
    );
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed, table-driven bench for btn_conditioner with short timing parameters.
module tb_btn_conditioner;
    localparam int N = 9;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    btn_conditioner_if #(.N(N)) bus ();

    btn_conditioner #(
        .N            (N),
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (10),
        .REPEAT_RATE  (5),
        .REPEAT_MASK  (9'h001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] l, input logic [N-1:0] p,
                           input logic [N-1:0] r);
        chk({tag, ".level"}, bus.btn_level, l);
        chk({tag, ".press"}, bus.btn_press, p);
        chk({tag, ".release"}, bus.btn_release, r);
    endtask

    function automatic void add(input logic [N-1:0] r, input logic [N-1:0] l,
                                input logic [N-1:0] p, input logic [N-1:0] rl);
        vec_t v;
        v.raw = r;
        v.lvl = l;
        v.prs = p;
        v.rel = rl;
        vecs.push_back(v);
    endfunction

    initial begin
        // Clean press on ch3 then release (edges relative to first raw sample).
        for (int e = 0; e <= 16; e++)
            add((e < 10) ? 9'h008 : 9'h000,
                (e >= 5 && e < 15) ? 9'h008 : 9'h000,
                (e == 5) ? 9'h008 : 9'h000,
                (e == 15) ? 9'h008 : 9'h000);
        // Bounce on ch1: 3-cycle runs never reach the 4-cycle threshold.
        for (int e = 0; e < 38; e++)
            add((e < 30 && ((e / 3) % 2 == 0)) ? 9'h002 : 9'h000, 9'h000, 9'h000, 9'h000);
        // Hold ch0 (repeat enabled) and ch2 (not enabled) for 40 cycles.
        for (int e = 0; e <= 59; e++)
            add((e < 40) ? 9'h005 : 9'h000,
                (e >= 5 && e < 45) ? 9'h005 : 9'h000,
                (e == 5) ? 9'h005 :
                    ((e >= 15 && e <= 40 && ((e - 15) % 5 == 0)) ? 9'h001 : 9'h000),
                (e == 45) ? 9'h005 : 9'h000);
        // All channels at once.
        for (int e = 0; e <= 16; e++)
            add((e < 8) ? 9'h1FF : 9'h000,
                (e >= 5 && e < 13) ? 9'h1FF : 9'h000,
                (e == 5) ? 9'h1FF : 9'h000,
                (e == 13) ? 9'h1FF : 9'h000);

        // Power-on reset.
        bus.btn_raw = 9'h000;
        #2 rst = 1'b0;
        tick();
        tick();
        chk_all("reset", 9'h000, 9'h000, 9'h000);
        #2 rst = 1'b1;

        // Table-driven vectors: raw applied before edge k, outputs checked after it.
        for (int k = 0; k < vecs.size(); k++) begin
            bus.btn_raw = vecs[k].raw;
            tick();
            chk_all($sformatf("vec%0d", k), vecs[k].lvl, vecs[k].prs, vecs[k].rel);
        end

        // Async reset mid-count on ch4, between edges 3 and 4.
        bus.btn_raw = 9'h010;
        for (int e = 0; e <= 3; e++) begin
            tick();
            chk_all($sformatf("rstcnt_e%0d", e), 9'h000, 9'h000, 9'h000);
        end
        #2 rst = 1'b0;
        #1 chk_all("rstcnt_async", 9'h000, 9'h000, 9'h000);
        tick();
        #2 rst = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk_all($sformatf("rstcnt_after_e%0d", e), (e >= 5) ? 9'h010 : 9'h000,
                    (e == 5) ? 9'h010 : 9'h000, 9'h000);
        end

        // Async reset while ch4 is held high with level=1: clears at once and re-presses.
        tick();
        chk("rsthold_pre.level", bus.btn_level, 9'h010);
        #2 rst = 1'b0;
        #1 chk_all("rsthold_async", 9'h000, 9'h000, 9'h000);
        tick();
        #2 rst = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk_all($sformatf("rsthold_after_e%0d", e), (e >= 5) ? 9'h010 : 9'h000,
                    (e == 5) ? 9'h010 : 9'h000, 9'h000);
        end
        bus.btn_raw = 9'h000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk_all($sformatf("rsthold_rel_e%0d", e), (e < 5) ? 9'h010 : 9'h000,
                    9'h000, (e == 5) ? 9'h010 : 9'h000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
